master_req_queue: RTL
=====================

MASTER_REQ_QUEUE -- requirements
Module: master_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set queue entries; legal values are powers of two, 2 to 16.
REQ-002 Parameter AW, default 32, SHALL set address width; address bit AW-1 SHALL select the slave.
REQ-003 Parameter DW, default 32, SHALL set data width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 m_valid  in  1  master offers a transaction.
REQ-007 m_addr  in  AW  transaction address.
REQ-008 m_we  in  1  1 = write, 0 = read.
REQ-009 m_wdata  in  DW  write data.
REQ-010 m_ready  out  1  queue accepts; a transfer occurs when m_valid & m_ready.
REQ-011 req_s0, req_s1  out  1 each  request to the arbiter of slave 0 or slave 1.
REQ-012 gnt_s0, gnt_s1  in  1 each  this master's bit of the corresponding arbiter's grant.
REQ-013 ack_s0, ack_s1  in  1 each  slave completion strobe.
REQ-014 rdata_s0, rdata_s1  in  DW each  slave read data, valid with ack.
REQ-015 s_addr, s_we, s_wdata  out  AW/1/DW  head-entry fields, broadcast to both slaves.
REQ-016 m_rvalid  out  1  one-cycle completion pulse to master.
REQ-017 m_rdata  out  DW  read data, valid while m_rvalid=1 (zero for writes).

Function
REQ-018 Queue SHALL be a circular FIFO of DEPTH entries {addr, we, wdata} with log2(DEPTH)+1-bit read/write pointers; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-019 m_ready SHALL equal !full, combinationally.
REQ-020 Push SHALL occur on m_valid & m_ready; pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 FSM states: IDLE, REQ, RESP.
REQ-022 IDLE -> REQ when queue non-empty at a clock edge; otherwise stay IDLE.
REQ-023 In REQ, req_sX SHALL be 1 only for X = head addr[AW-1]; the other req SHALL be 0; in IDLE and RESP both req SHALL be 0.
REQ-024 In REQ, completion SHALL be gnt_sX & ack_sX for the selected X; ack or grant on the unselected slave SHALL be ignored.
REQ-025 On completion: pop head, capture rdata_sX (or zero if write) into m_rdata, go to RESP.
REQ-026 RESP SHALL last exactly one cycle with m_rvalid=1, then go to IDLE.
REQ-027 Minimum head-to-next-request spacing SHALL therefore be REQ->RESP->IDLE->REQ: one transaction per 3 cycles at best.
REQ-028 Simultaneous push and pop SHALL both take effect; count is unchanged; push when full SHALL be blocked by m_ready=0 even if a pop occurs in that cycle.
REQ-029 s_addr/s_we/s_wdata SHALL present the head entry whenever non-empty and SHALL stay stable through REQ.
REQ-030 Grant without ack SHALL hold REQ indefinitely (no timeout).

Reset
REQ-031 While reset=0: pointers 0, state IDLE, req_s0=req_s1=0, m_rvalid=0, m_rdata=0, m_ready=1.
REQ-032 Reset asserted mid-transaction SHALL discard all queued entries and any pending completion; no m_rvalid SHALL follow.
REQ-033 Queue storage SHALL not require reset.

Structure
REQ-034 State encodings and the slave-select bit index SHALL live in a shared package with the arbiter constants.
REQ-035 FIFO storage/pointers SHALL be one sub-module, req_fifo; FSM and slave decode stay in master_req_queue.

Verification
REQ-036 Single read: push addr=0x0000_0010, we=0; gnt_s0 & ack_s0 with rdata_s0=0xA5A5_A5A5 two cycles after REQ -> req_s0 only, one m_rvalid with m_rdata=0xA5A5_A5A5.
REQ-037 Fill: push 4 entries with no grant -> m_ready=0 after 4th; a 5th offer is not accepted until first pop.
REQ-038 Slave routing: push addr=0x8000_0000 write -> req_s1=1, req_s0=0; ack_s0 alone does not complete; gnt_s1&ack_s1 -> m_rvalid with m_rdata=0.
REQ-039 Wrap: push/complete 10 transactions back-to-back at DEPTH=4 -> all 10 complete in order, addresses match.
REQ-040 Simultaneous push/pop at full: pop and offer in the same cycle -> offer not accepted that cycle, accepted next.
REQ-041 Reset mid-REQ: reset=0 for one cycle while REQ -> req lines drop, queue empty, no m_rvalid.

Source files
------------

// File: rtl/master_req_queue_pkg.sv
// Shared definitions for the master request queue: FSM encodings,
// slave-select bit location and constants shared with the slave arbiters.
package master_req_queue_pkg;

    // Request FSM: wait for a head entry, request its slave, pulse completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Arbiter-side constants: two slaves, one select bit.
    localparam int NUM_SLAVES     = 2;
    localparam int SLAVE_SEL_BITS = 1;

    // The top address bit picks the slave.
    function automatic int sel_bit_idx(input int aw);
        return aw - 1;
    endfunction

    // Pointers carry one extra wrap bit to tell full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Circular FIFO holding {addr, we, wdata} transactions. The head entry is
// always visible on the head_* outputs; storage itself carries no reset.
module req_fifo
    import master_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic          push_we,
    input  logic [DW-1:0] push_wdata,
    output logic [AW-1:0] head_addr,
    output logic          head_we,
    output logic [DW-1:0] head_wdata,
    output logic          full,
    output logic          empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [AW-1:0] addr_mem  [DEPTH];
    logic          we_mem    [DEPTH];
    logic [DW-1:0] wdata_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow regardless of what the caller does.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign head_addr  = addr_mem[rd_ptr[IW-1:0]];
    assign head_we    = we_mem[rd_ptr[IW-1:0]];
    assign head_wdata = wdata_mem[rd_ptr[IW-1:0]];

    // Pointer update; low bits wrap naturally from DEPTH-1 to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Entry storage write on push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr[IW-1:0]]  <= push_addr;
            we_mem[wr_ptr[IW-1:0]]    <= push_we;
            wdata_mem[wr_ptr[IW-1:0]] <= push_wdata;
        end
    end

endmodule

// File: rtl/master_req_queue.sv
// Master-side request queue: buffers master transactions, requests the
// slave selected by the head address MSB, and returns a one-cycle
// completion pulse with read data.
//
// Handshakes: master transfer happens on a rising edge where
// m_valid & m_ready; slave completion happens on a rising edge in REQ where
// gnt_sX & ack_sX for the selected slave X. m_ready depends only on queue
// fullness, never on m_valid or on a same-cycle pop.
module master_req_queue
    import master_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m_valid,
    input  logic [AW-1:0] m_addr,
    input  logic          m_we,
    input  logic [DW-1:0] m_wdata,
    output logic          m_ready,
    output logic          req_s0,
    output logic          req_s1,
    input  logic          gnt_s0,
    input  logic          gnt_s1,
    input  logic          ack_s0,
    input  logic          ack_s1,
    input  logic [DW-1:0] rdata_s0,
    input  logic [DW-1:0] rdata_s1,
    output logic [AW-1:0] s_addr,
    output logic          s_we,
    output logic [DW-1:0] s_wdata,
    output logic          m_rvalid,
    output logic [DW-1:0] m_rdata,
    output logic [1:0]    fsm_state
);

    localparam int SEL_IDX = sel_bit_idx(AW);

    state_t state;
    state_t next_state;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          sel;
    logic          done;
    logic [DW-1:0] resp_data;

    assign m_ready   = ~full;
    assign push      = m_valid & m_ready;
    assign sel       = s_addr[SEL_IDX];
    assign m_rvalid  = (state == ST_RESP);
    assign fsm_state = state;

    req_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_addr  (m_addr),
        .push_we    (m_we),
        .push_wdata (m_wdata),
        .head_addr  (s_addr),
        .head_we    (s_we),
        .head_wdata (s_wdata),
        .full       (full),
        .empty      (empty)
    );

    // Completion only counts on the selected slave; the other is ignored.
    always_comb begin
        done      = '0;
        resp_data = '0;
        if (sel) begin
            done = gnt_s1 & ack_s1;
            if (!s_we) resp_data = rdata_s1;
        end else begin
            done = gnt_s0 & ack_s0;
            if (!s_we) resp_data = rdata_s0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state, slave request decode and pop generation.
    always_comb begin
        next_state = state;
        req_s0     = 1'b0;
        req_s1     = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) next_state = ST_REQ;
            end
            ST_REQ: begin
                req_s0 = ~sel;
                req_s1 = sel;
                if (done) begin
                    pop        = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the completion data (zero for writes) as the head is popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   m_rdata <= '0;
        else if (pop) m_rdata <= resp_data;
    end

endmodule
